cs_seq: RTL and testbench

CS_SEQ -- requirements
Module: cs_seq

---
 rtl/cs_seq.sv | 151 +++++++++++++++
 tb/tb_cs_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_seq.sv
// cs_seq: ADC acquisition sequencer. Checks and configures the front end once, then for each
// sample tick reads the enabled channels, pushes to the FIFO and sends over UDP, with handshake timeouts.
module cs_seq #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TMO   = 50000
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr_err,
    input  logic [NCH-1:0]   ch_en,
    input  logic             fs_adc,
    input  logic             fifod_full,
    output logic             fs_adc_check,
    input  logic             fd_adc_check,
    output logic             fs_adc_conf,
    input  logic             fd_adc_conf,
    output logic             fs_adc_fifo,
    input  logic             fd_adc_fifo,
    output logic             fs_udp_tx,
    input  logic             fd_udp_tx,
    output logic [NCH-1:0]   fs_adc_read,
    input  logic [NCH-1:0]   fd_adc_read,
    output logic [CNT_W-1:0] adc_cnt,
    output logic [7:0]       drop_cnt,
    output logic [2:0]       err_code,
    output logic             busy,
    output logic             rst_run
);
    localparam int unsigned TMO_W = $clog2(TMO + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_CONF  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_FIFO  = 3'd5;
    localparam logic [2:0] S_TX    = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    logic [2:0]       state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             in_hs;
    logic             done;
    logic [2:0]       fail_code;
    logic             tmo_hit;
    logic             drop_hit;

    always_comb begin
        in_hs     = 1'b1;
        done      = 1'b0;
        fail_code = 3'd0;
        case (state)
            S_CHECK: begin done = fd_adc_check; fail_code = 3'd1; end
            S_CONF:  begin done = fd_adc_conf;  fail_code = 3'd2; end
            // READ completes once every still-pending channel has its fd this cycle
            S_READ:  begin done = ((fs_adc_read & ~fd_adc_read) == '0); fail_code = 3'd3; end
            S_FIFO:  begin done = fd_adc_fifo;  fail_code = 3'd4; end
            S_TX:    begin done = fd_udp_tx;    fail_code = 3'd5; end
            default: in_hs = 1'b0;
        endcase
    end

    // a returning fd wins over a timeout landing on the same edge
    assign tmo_hit  = in_hs && !done && (tmo_cnt == TMO_W'(TMO - 1));
    assign drop_hit = fs_adc && (((state == S_WAIT) && fifod_full && (ch_en != '0)) ||
                                 (state == S_READ) || (state == S_FIFO) || (state == S_TX));
    assign busy     = (state != S_IDLE) && (state != S_ERR);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state        <= S_IDLE;
            tmo_cnt      <= '0;
            fs_adc_check <= 1'b0;
            fs_adc_conf  <= 1'b0;
            fs_adc_fifo  <= 1'b0;
            fs_udp_tx    <= 1'b0;
            fs_adc_read  <= '0;
            adc_cnt      <= '0;
            drop_cnt     <= '0;
            err_code     <= '0;
            rst_run      <= 1'b0;
        end else begin
            rst_run <= 1'b0;
            if (in_hs) tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (drop_hit && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;

            if (tmo_hit) begin
                state        <= S_ERR;
                tmo_cnt      <= '0;
                fs_adc_check <= 1'b0;
                fs_adc_conf  <= 1'b0;
                fs_adc_fifo  <= 1'b0;
                fs_udp_tx    <= 1'b0;
                fs_adc_read  <= '0;
                err_code     <= fail_code;
                rst_run      <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        state        <= S_CHECK;
                        fs_adc_check <= 1'b1;
                        tmo_cnt      <= '0;
                    end
                    S_CHECK: if (done) begin
                        state        <= S_CONF;
                        fs_adc_check <= 1'b0;
                        fs_adc_conf  <= 1'b1;
                        tmo_cnt      <= '0;
                    end
                    S_CONF: if (done) begin
                        state       <= S_WAIT;
                        fs_adc_conf <= 1'b0;
                    end
                    S_WAIT: if (fs_adc && !fifod_full && (ch_en != '0)) begin
                        state       <= S_READ;
                        fs_adc_read <= ch_en;
                        tmo_cnt     <= '0;
                    end
                    S_READ: begin
                        fs_adc_read <= fs_adc_read & ~fd_adc_read;
                        if (done) begin
                            state       <= S_FIFO;
                            fs_adc_fifo <= 1'b1;
                            tmo_cnt     <= '0;
                        end
                    end
                    S_FIFO: if (done) begin
                        state       <= S_TX;
                        fs_adc_fifo <= 1'b0;
                        fs_udp_tx   <= 1'b1;
                        tmo_cnt     <= '0;
                    end
                    S_TX: if (done) begin
                        state     <= S_WAIT;
                        fs_udp_tx <= 1'b0;
                        adc_cnt   <= adc_cnt + CNT_W'(1);
                    end
                    S_ERR: if (clr_err) begin
                        state        <= S_CHECK;
                        err_code     <= '0;
                        fs_adc_check <= 1'b1;
                        tmo_cnt      <= '0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cs_seq.sv
// tb_cs_seq: directed + randomized handshake scenarios for cs_seq, checked against
// expected flag timing derived from the handshake rules and counter models kept here.
module tb_cs_seq;
    localparam int NCH      = 4;
    localparam int CNT_W    = 8;
    localparam int TMO      = 16;
    localparam int ST_CHECK = 0;
    localparam int ST_CONF  = 1;
    localparam int ST_FIFO  = 2;
    localparam int ST_TX    = 3;
    localparam int ST_READ  = -1;

    logic             sys_clk = 1'b0;
    logic             rst, start, clr_err, fs_adc, fifod_full;
    logic [NCH-1:0]   ch_en, fs_adc_read, fd_adc_read;
    logic             fs_adc_check, fd_adc_check, fs_adc_conf, fd_adc_conf;
    logic             fs_adc_fifo, fd_adc_fifo, fs_udp_tx, fd_udp_tx;
    logic [CNT_W-1:0] adc_cnt;
    logic [7:0]       drop_cnt;
    logic [2:0]       err_code;
    logic             busy, rst_run;
    logic [3:0]       fs_vec;

    int vectors     = 0;
    int miscompares = 0;
    int exp_adc     = 0;
    int exp_drop    = 0;

    always #5 sys_clk = ~sys_clk;
    assign fs_vec = {fs_udp_tx, fs_adc_fifo, fs_adc_conf, fs_adc_check};

    cs_seq #(.NCH(NCH), .CNT_W(CNT_W), .TMO(TMO)) dut (
        .sys_clk(sys_clk), .rst(rst), .start(start), .clr_err(clr_err),
        .ch_en(ch_en), .fs_adc(fs_adc), .fifod_full(fifod_full),
        .fs_adc_check(fs_adc_check), .fd_adc_check(fd_adc_check),
        .fs_adc_conf(fs_adc_conf), .fd_adc_conf(fd_adc_conf),
        .fs_adc_fifo(fs_adc_fifo), .fd_adc_fifo(fd_adc_fifo),
        .fs_udp_tx(fs_udp_tx), .fd_udp_tx(fd_udp_tx),
        .fs_adc_read(fs_adc_read), .fd_adc_read(fd_adc_read),
        .adc_cnt(adc_cnt), .drop_cnt(drop_cnt), .err_code(err_code),
        .busy(busy), .rst_run(rst_run)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic note_drop();
        if (exp_drop < 255) exp_drop++;
    endtask

    task automatic set_fd(input int st, input logic v);
        case (st)
            ST_CHECK: fd_adc_check = v;
            ST_CONF:  fd_adc_conf  = v;
            ST_FIFO:  fd_adc_fifo  = v;
            default:  fd_udp_tx    = v;
        endcase
    endtask

    task automatic chk_state(input string tag, input logic [3:0] exp_fs, input logic [NCH-1:0] exp_rd);
        chk({tag, ".fs"}, 32'(fs_vec), 32'(exp_fs));
        chk({tag, ".rd"}, 32'(fs_adc_read), 32'(exp_rd));
    endtask

    task automatic chk_wait(input string tag);
        chk_state(tag, 4'b0, '0);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".err"}, 32'(err_code), 32'd0);
        chk({tag, ".adc"}, 32'(adc_cnt), 32'(exp_adc));
        chk({tag, ".drop"}, 32'(drop_cnt), 32'(exp_drop));
    endtask

    task automatic chk_reset(input string tag);
        exp_adc  = 0;
        exp_drop = 0;
        chk_state(tag, 4'b0, '0);
        chk({tag, ".adc"}, 32'(adc_cnt), 32'd0);
        chk({tag, ".drop"}, 32'(drop_cnt), 32'd0);
        chk({tag, ".err"}, 32'(err_code), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".rst_run"}, 32'(rst_run), 32'd0);
    endtask

    // single-flag stage: fs must stay high through the cycle fd is returned, dly cycles after entry
    task automatic serve(input int st, input int dly, input bit tick_at_done);
        for (int c = 0; c <= dly; c++) begin
            chk_state($sformatf("serve%0d.c%0d", st, c), 4'(1 << st), '0);
            fs_adc = (c == dly && tick_at_done) ? 1'b1 : ($urandom_range(0, 3) == 0);
            if (fs_adc && (st == ST_FIFO || st == ST_TX)) note_drop();
            if (c == dly) set_fd(st, 1'b1);
            tick();
            set_fd(st, 1'b0);
            fs_adc = 1'b0;
        end
    endtask

    task automatic serve_read(input logic [NCH-1:0] mask, input int dly [NCH]);
        int last = 0;
        logic [NCH-1:0] pend;
        for (int i = 0; i < NCH; i++) if (mask[i] && dly[i] > last) last = dly[i];
        for (int c = 0; c <= last; c++) begin
            for (int i = 0; i < NCH; i++) pend[i] = mask[i] && (c <= dly[i]);
            chk_state($sformatf("read.c%0d", c), 4'b0, pend);
            for (int i = 0; i < NCH; i++)
                fd_adc_read[i] = mask[i] ? (c == dly[i]) : 1'($urandom_range(0, 1));
            ch_en  = NCH'($urandom);
            fs_adc = ($urandom_range(0, 3) == 0);
            if (fs_adc) note_drop();
            tick();
        end
        fd_adc_read = '0;
        fs_adc      = 1'b0;
        ch_en       = mask;
    endtask

    task automatic tick_adc(input logic [NCH-1:0] mask);
        ch_en      = mask;
        fifod_full = 1'b0;
        fs_adc     = 1'b1;
        tick();
        fs_adc     = 1'b0;
    endtask

    task automatic run_cycle(input logic [NCH-1:0] mask, input int dmax, input int fifo_d, input int tx_d);
        int d [NCH];
        for (int i = 0; i < NCH; i++) d[i] = $urandom_range(0, dmax);
        tick_adc(mask);
        serve_read(mask, d);
        serve(ST_FIFO, fifo_d, 1'b0);
        serve(ST_TX, tx_d, 1'b0);
        exp_adc = (exp_adc + 1) % (1 << CNT_W);
        chk_wait("cycle");
    endtask

    task automatic wait_noise(input int n);
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 2))
                0: begin fifod_full = 1'b1; ch_en = NCH'($urandom_range(1, 15)); fs_adc = 1'b1; note_drop(); end
                1: begin fifod_full = 1'b0; ch_en = '0; fs_adc = 1'b1; end
                default: fs_adc = 1'b0;
            endcase
            tick();
            fs_adc     = 1'b0;
            fifod_full = 1'b0;
            chk_wait("noise");
        end
    endtask

    // stage left unanswered: TMO cycles of fs, then ERR with a single rst_run cycle
    task automatic timeout(input int st, input int code, input logic [NCH-1:0] mask);
        for (int c = 0; c < TMO; c++) begin
            if (st == ST_READ) chk_state($sformatf("tmo_read.c%0d", c), 4'b0, mask);
            else chk_state($sformatf("tmo%0d.c%0d", st, c), 4'(1 << st), '0);
            tick();
        end
        chk_state("tmo.err", 4'b0, '0);
        chk("tmo.rst_run", 32'(rst_run), 32'd1);
        chk("tmo.code", 32'(err_code), 32'(code));
        chk("tmo.busy", 32'(busy), 32'd0);
        chk("tmo.adc", 32'(adc_cnt), 32'(exp_adc));
        chk("tmo.drop", 32'(drop_cnt), 32'(exp_drop));
        tick();
        chk("tmo.rst_run_end", 32'(rst_run), 32'd0);
        chk("tmo.code_hold", 32'(err_code), 32'(code));
    endtask

    task automatic recover();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr.err", 32'(err_code), 32'd0);
        chk("clr.busy", 32'(busy), 32'd1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d [NCH];
        rst = 1'b1; start = 1'b0; clr_err = 1'b0; fs_adc = 1'b0; fifod_full = 1'b0;
        ch_en = '0; fd_adc_read = '0;
        fd_adc_check = 1'b0; fd_adc_conf = 1'b0; fd_adc_fifo = 1'b0; fd_udp_tx = 1'b0;
        tick(); tick();
        chk_reset("reset");
        rst = 1'b0;

        // IDLE ignores ticks and clr_err
        fs_adc = 1'b1; clr_err = 1'b1; ch_en = 4'hF;
        tick();
        fs_adc = 1'b0; clr_err = 1'b0;
        chk_reset("idle");

        start = 1'b1; tick(); start = 1'b0;
        timeout(ST_CHECK, 1, '0);
        start = 1'b1; fs_adc = 1'b1;
        tick();
        start = 1'b0; fs_adc = 1'b0;
        chk_state("err_hold", 4'b0, '0);
        chk("err_hold.busy", 32'(busy), 32'd0);
        chk("err_hold.drop", 32'(drop_cnt), 32'd0);
        recover();
        serve(ST_CHECK, 3, 1'b0);
        serve(ST_CONF, 3, 1'b0);
        chk_wait("bringup");

        // two-of-four channels with staggered returns; tick on TX completion is a drop
        tick_adc(4'b0101);
        d = '{1, 0, 4, 0};
        serve_read(4'b0101, d);
        serve(ST_FIFO, 2, 1'b0);
        serve(ST_TX, 2, 1'b1);
        exp_adc = (exp_adc + 1) % (1 << CNT_W);
        chk_wait("two_ch");
        chk("two_ch.adc_one", 32'(adc_cnt), 32'd1);
        tick();
        chk_wait("two_ch.stay");

        for (int n = 0; n < 40; n++) begin
            run_cycle(NCH'($urandom_range(1, 15)), TMO - 1, $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1));
            wait_noise(3);
        end

        // fd on the last cycle before the timeout limit completes the stage
        tick_adc(4'b1000);
        d = '{0, 0, 0, TMO - 1};
        serve_read(4'b1000, d);
        serve(ST_FIFO, TMO - 1, 1'b0);
        serve(ST_TX, TMO - 1, 1'b0);
        exp_adc = (exp_adc + 1) % (1 << CNT_W);
        chk_wait("edge_fd");

        tick_adc(4'b0110);
        timeout(ST_READ, 3, 4'b0110);
        recover();
        serve(ST_CHECK, 1, 1'b0);
        timeout(ST_CONF, 2, '0);
        recover();
        serve(ST_CHECK, 0, 1'b0);
        serve(ST_CONF, TMO - 1, 1'b0);
        chk_wait("conf_edge");

        tick_adc(4'b0001);
        d = '{2, 0, 0, 0};
        serve_read(4'b0001, d);
        timeout(ST_FIFO, 4, '0);
        recover();
        serve(ST_CHECK, 0, 1'b0);
        serve(ST_CONF, 0, 1'b0);
        tick_adc(4'b0001);
        serve_read(4'b0001, d);
        serve(ST_FIFO, 1, 1'b0);
        timeout(ST_TX, 5, '0);
        recover();
        serve(ST_CHECK, 0, 1'b0);
        serve(ST_CONF, 0, 1'b0);
        chk_wait("after_tx_tmo");

        // FIFO full: every tick is a drop, saturating
        ch_en = 4'hF;
        fifod_full = 1'b1;
        for (int n = 0; n < 300; n++) begin
            fs_adc = 1'b1; note_drop();
            tick();
            fs_adc = 1'b0;
            tick();
        end
        fifod_full = 1'b0;
        chk("sat.drop", 32'(drop_cnt), 32'd255);
        chk_wait("sat");

        rst = 1'b1; tick(); rst = 1'b0;
        chk_reset("rst2");
        start = 1'b1; tick(); start = 1'b0;
        serve(ST_CHECK, 0, 1'b0);
        serve(ST_CONF, 0, 1'b0);
        for (int n = 0; n < 256; n++) run_cycle(NCH'($urandom_range(1, 15)), 0, 0, 0);
        chk("wrap.adc", 32'(adc_cnt), 32'd0);

        // reset mid-FIFO handshake beats fd, start and tick
        tick_adc(4'b0011);
        d = '{0, 1, 0, 0};
        serve_read(4'b0011, d);
        chk("pre_rst.fifo", 32'(fs_adc_fifo), 32'd1);
        rst = 1'b1; fd_adc_fifo = 1'b1; start = 1'b1; fs_adc = 1'b1;
        tick();
        rst = 1'b0; fd_adc_fifo = 1'b0; start = 1'b0; fs_adc = 1'b0;
        chk_reset("mid_rst");
        fs_adc = 1'b1; tick(); fs_adc = 1'b0;
        chk_reset("mid_rst.idle");
        start = 1'b1; tick(); start = 1'b0;
        chk_state("restart", 4'b0001, '0);
        chk("restart.busy", 32'(busy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
